// File: rtl/mmio_reg_bank.sv
// Memory-mapped bank of REGS 32-bit registers with byte-lane writes,
// per-register hardware update ports and a three-state bus responder.
//
// Handshake: the master raises req and holds it together with addr_bus,
// data_in, byte_enable, rd and wr until it sees ack or err. The access is
// captured in the cycle where req && addr_hit is seen in IDLE. Exactly one of
// ack/err is high for the single RESP cycle that follows. The FSM then waits
// in HOLD until req falls, so a held req is never serviced twice.
module mmio_reg_bank #(
  parameter logic [31:0]        START_ADDR  = 32'h0,
  parameter int                 REGS        = 4,
  parameter logic [REGS-1:0]    WRITABLE    = '1,
  parameter logic [REGS*32-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr_bus,
  input  logic [31:0]          data_in,
  input  logic [3:0]           byte_enable,
  input  logic                 req,
  input  logic                 wr,
  input  logic                 rd,
  output logic                 addr_hit,
  output logic [31:0]          data_out,
  output logic                 ack,
  output logic                 err,
  output logic [REGS*32-1:0]   regs_out,
  input  logic [REGS-1:0]      hw_we,
  input  logic [REGS*32-1:0]   hw_data,
  output logic [REGS-1:0]      wr_strobe,
  output logic [1:0]           fsm_state
);

  localparam int REG_BITS = $clog2(REGS);
  localparam int IDX_W    = (REG_BITS == 0) ? 1 : REG_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q;
  logic [31:0]      regs_q [REGS];
  logic [IDX_W-1:0] idx_now;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;
  logic [3:0]       be_q;
  logic             rd_q;
  logic             wr_q;
  logic             misalign_q;
  logic             accept;
  logic             in_resp;
  logic             bad;

  assign addr_hit  = (addr_bus[31:REG_BITS+2] == START_ADDR[31:REG_BITS+2]);
  assign accept    = (state_q == ST_IDLE) && req && addr_hit;
  assign fsm_state = state_q;

  // A single-register bank has no index bits in the address.
  generate
    if (REGS == 1) begin : g_idx_single
      assign idx_now = '0;
    end else begin : g_idx_multi
      assign idx_now = addr_bus[REG_BITS+1:2];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < REGS; gi++) begin : g_out
      assign regs_out[gi*32 +: 32] = regs_q[gi];
    end
  endgenerate

  // Access FSM: IDLE -> RESP on accept, RESP -> HOLD, HOLD -> IDLE once req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_RESP;
        ST_RESP: state_q <= ST_HOLD;
        ST_HOLD: if (!req) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture the access attributes in the accepting cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      data_q     <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      idx_q      <= idx_now;
      data_q     <= data_in;
      be_q       <= byte_enable;
      rd_q       <= rd;
      wr_q       <= wr;
      misalign_q <= (addr_bus[1:0] != 2'b00);
    end
  end

  // Response decode; rst masks the RESP cycle so an aborted access never completes.
  always_comb begin
    bad       = (rd_q && wr_q) || (!rd_q && !wr_q) || misalign_q ||
                (wr_q && (be_q == 4'b0000)) || (wr_q && !WRITABLE[idx_q]);
    in_resp   = (state_q == ST_RESP) && !rst;
    ack       = in_resp && !bad;
    err       = in_resp && bad;
    data_out  = (ack && rd_q) ? regs_q[idx_q] : 32'h0;
    wr_strobe = '0;
    if (ack && wr_q) wr_strobe[idx_q] = 1'b1;
  end

  // Register storage: bus data owns its enabled lanes, hw_data fills the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= RESET_VALUE[i*32 +: 32];
    end else begin
      for (int i = 0; i < REGS; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_strobe[i] && be_q[k]) begin
            regs_q[i][k*8 +: 8] <= data_q[k*8 +: 8];
          end else if (hw_we[i]) begin
            regs_q[i][k*8 +: 8] <= hw_data[i*32 + k*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/mmio_reg_bank.md
MMIO_REG_BANK -- requirements
Module: mmio_reg_bank

Interface
REQ-001 Parameter START_ADDR, default 32'h0: device base address; SHALL be aligned to REGS*4 bytes.
REQ-002 Parameter REGS, default 4: number of 32-bit registers; SHALL be a power of two, 1..256.
REQ-003 Parameter WRITABLE, default all ones, REGS bits: bit i set = register i is bus-writable.
REQ-004 Parameter RESET_VALUE, default 0, REGS*32 bits: reset contents; register i occupies bits [32i+31:32i].
REQ-005 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port addr_bus, input, 32: byte address of the access.
REQ-008 Port data_in, input, 32: write data.
REQ-009 Port byte_enable, input, 4: write lane enables; bit k = bits [8k+7:8k].
REQ-010 Port req, input, 1: access request, held by master until ack or err.
REQ-011 Port wr and rd, input, 1 each: access type.
REQ-012 Port addr_hit, output, 1: combinational; addr_bus[31:REG_BITS+2] equals START_ADDR[31:REG_BITS+2], REG_BITS = clog2(REGS).
REQ-013 Port data_out, output, 32: read data, valid only while ack is high, otherwise 0.
REQ-014 Port ack and err, output, 1 each: one-cycle completion pulses; never both high.
REQ-015 Port regs_out, output, REGS*32: current contents of all registers.
REQ-016 Port hw_we, input, REGS: per-register hardware update enable; hw_data, input, REGS*32: update values.
REQ-017 Port wr_strobe, output, REGS: one-cycle pulse for each register updated by a bus write.

Function
REQ-018 FSM states: IDLE, RESP, HOLD.
REQ-019 IDLE -> RESP when req && addr_hit; the access is captured in that cycle (address, data, lanes, type).
REQ-020 req without addr_hit: FSM SHALL stay in IDLE, no ack, no err, no register change.
REQ-021 In RESP, exactly one of ack or err SHALL be high; RESP -> HOLD unconditionally. Latency from accepted req to response: 1 cycle.
REQ-022 HOLD -> IDLE when req low; while req stays high in HOLD, no new access SHALL be accepted.
REQ-023 Error conditions (checked on the captured access): rd && wr; neither rd nor wr; addr_bus[1:0] != 0; write with byte_enable == 0; write to a register with WRITABLE bit clear.
REQ-024 On error: err pulse, data_out 0, no register or wr_strobe change.
REQ-025 Valid write: enabled lanes of register reg_index are updated at the RESP edge; disabled lanes keep their value; wr_strobe[reg_index] pulses together with ack.
REQ-026 Valid read: data_out = register contents at the RESP cycle, including any hw update committed at the preceding edge.
REQ-027 reg_index = addr_bus[REG_BITS+1:2]; for REGS == 1, reg_index SHALL be constant 0.
REQ-028 hw_we[i] loads hw_data for register i every cycle in which it is asserted, in any FSM state, regardless of WRITABLE.
REQ-029 Bus write and hw_we on the same register in the same cycle: bus data wins on enabled lanes, hw_data on the remaining lanes.
REQ-030 Addresses beyond register space cannot occur: the hit range covers exactly REGS words.

Reset
REQ-031 rst high at a clock edge: FSM -> IDLE; ack, err, wr_strobe and data_out = 0; registers = RESET_VALUE; hw_we is ignored in that cycle.
REQ-032 rst during RESP or HOLD SHALL abort the access with no response; after reset release, a still-high req with addr_hit is accepted as a new access.

Verification
REQ-033 REGS=4, START_ADDR=32'h1000: write 32'hDEADBEEF to 0x1008 with byte_enable 4'b1111 -> ack one cycle after req, wr_strobe=4'b0100, regs_out reg2 = DEADBEEF; then a read of 0x1008 returns DEADBEEF.
REQ-034 Partial write of 32'h11223344 with byte_enable 4'b0101 to 0x1008 holding DEADBEEF -> reg2 = DE22BE44.
REQ-035 WRITABLE=4'b1110: write to 0x1000 -> err pulse, reg0 unchanged; read of 0x1002 -> err; req to 0x2000 -> no response, addr_hit 0.
REQ-036 Same-cycle hw_we[1] with hw_data=32'hAAAAAAAA and bus write of 32'h55555555 to 0x1004, byte_enable 4'b0011 -> reg1 = AAAA5555.
REQ-037 req held high for 5 cycles -> exactly one ack; req dropped and raised again -> second ack.
REQ-038 rst asserted in RESP -> no ack, all registers = RESET_VALUE, FSM in IDLE on the next cycle.
